// File: rtl/c2c_pkg.sv
// Shared types and helpers for the chip-to-chip burst slave controller.
package c2c_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        NOTICE       = 2'd1,
        WAIT_DATA    = 2'd2,
        WAIT_RELEASE = 2'd3
    } c2c_state_e;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned c2c_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/c2c_delay_counter.sv
// One-shot delay: done goes high CYCLES-1 cycles after start and stays high for one cycle.
module c2c_delay_counter
    import c2c_pkg::*;
#(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned CW = c2c_cnt_width(CYCLES);

    logic [CW-1:0] cnt_q;
    logic          run_q;

    // Loading CYCLES-1 makes the owner's state last exactly CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= CW'(CYCLES - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/c2c_burst_slave_ctrl.sv
// Chip-to-chip slave: request/notice phase, then a BURST_LEN-word ack/valid burst with a watchdog.
module c2c_burst_slave_ctrl
    import c2c_pkg::*;
#(
    parameter int unsigned DATA_W         = 3,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned NOTICE_CYCLES  = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  request,
    input  logic                                  valid,
    input  logic [DATA_W-1:0]                     data_in,
    output logic                                  ack,
    output logic                                  notice,
    output logic [DATA_W-1:0]                     data,
    output logic [c2c_cnt_width(BURST_LEN)-1:0]   word_cnt,
    output logic                                  data_strobe,
    output logic                                  burst_done,
    output logic                                  error
);

    localparam int unsigned CNT_W = c2c_cnt_width(BURST_LEN);
    localparam int unsigned TMO_W = c2c_cnt_width(TIMEOUT_CYCLES);

    c2c_state_e          state_q, state_d;
    logic                ack_q, ack_d;
    logic                notice_q, notice_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                notice_start;
    logic                notice_done;
    logic                tmo_hit;

    c2c_delay_counter #(
        .CYCLES (NOTICE_CYCLES)
    ) u_notice_delay (
        .clk   (clk),
        .rst   (rst),
        .start (notice_start),
        .done  (notice_done)
    );

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            notice_q <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            notice_q <= notice_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            error_q  <= error_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        notice_d     = notice_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        error_d      = error_q;
        notice_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (request) begin
                    state_d      = NOTICE;
                    notice_d     = 1'b1;
                    error_d      = 1'b0;
                    cnt_d        = '0;
                    notice_start = 1'b1;
                end
            end
            NOTICE: begin
                if (notice_done) begin
                    state_d  = WAIT_DATA;
                    notice_d = 1'b0;
                    ack_d    = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (valid) begin
                    state_d  = WAIT_RELEASE;
                    data_d   = data_in;
                    cnt_d    = cnt_q + 1'b1;
                    ack_d    = 1'b0;
                    strobe_d = 1'b1;
                end else if (!request) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    error_d = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (!valid) begin
                    if (cnt_q == CNT_W'(BURST_LEN)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_DATA;
                        ack_d   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog restarts on every state entry and only runs in the wait states.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (state_q == WAIT_DATA || state_q == WAIT_RELEASE) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end
    end

    assign ack         = ack_q;
    assign notice      = notice_q;
    assign data        = data_q;
    assign word_cnt    = cnt_q;
    assign data_strobe = strobe_q;
    assign burst_done  = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_c2c_burst_slave_ctrl.sv
// Directed bench: two configurations (3-word burst / single-word burst) with hand-derived expectations.
module tb_c2c_burst_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       request, valid;
    logic [2:0] data_in, data;
    logic [1:0] word_cnt;
    logic       ack, notice, data_strobe, burst_done, error;

    logic       request1, valid1;
    logic [7:0] data_in1, data1;
    logic [0:0] word_cnt1;
    logic       ack1, notice1, data_strobe1, burst_done1, error1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    c2c_burst_slave_ctrl #(
        .DATA_W(3), .BURST_LEN(3), .NOTICE_CYCLES(4), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .rst(rst), .request(request), .valid(valid), .data_in(data_in),
        .ack(ack), .notice(notice), .data(data), .word_cnt(word_cnt),
        .data_strobe(data_strobe), .burst_done(burst_done), .error(error)
    );

    c2c_burst_slave_ctrl #(
        .DATA_W(8), .BURST_LEN(1), .NOTICE_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .request(request1), .valid(valid1), .data_in(data_in1),
        .ack(ack1), .notice(notice1), .data(data1), .word_cnt(word_cnt1),
        .data_strobe(data_strobe1), .burst_done(burst_done1), .error(error1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ack"},         32'(ack),         32'd0);
        check({tag, ".notice"},      32'(notice),      32'd0);
        check({tag, ".data"},        32'(data),        32'd0);
        check({tag, ".word_cnt"},    32'(word_cnt),    32'd0);
        check({tag, ".data_strobe"}, 32'(data_strobe), 32'd0);
        check({tag, ".burst_done"},  32'(burst_done),  32'd0);
        check({tag, ".error"},       32'(error),       32'd0);
    endtask

    // Raise request and follow the 4-cycle notice phase until ack rises.
    task automatic start_burst(input string tag);
        request = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, ".notice"}, 32'(notice), 32'd1);
            check({tag, ".ack_lo"}, 32'(ack),    32'd0);
        end
        check({tag, ".error_clr"}, 32'(error),    32'd0);
        check({tag, ".cnt_clr"},   32'(word_cnt), 32'd0);
        @(negedge clk);
        check({tag, ".notice_off"}, 32'(notice), 32'd0);
        check({tag, ".ack_on"},     32'(ack),    32'd1);
    endtask

    // One valid handshake; last selects burst completion vs. return to WAIT_DATA.
    task automatic send_word(input string tag, input logic [2:0] w, input logic [1:0] cnt, input bit last);
        valid   = 1'b1;
        data_in = w;
        @(negedge clk);
        check({tag, ".data"},     32'(data),        32'(w));
        check({tag, ".strobe"},   32'(data_strobe), 32'd1);
        check({tag, ".word_cnt"}, 32'(word_cnt),    32'(cnt));
        check({tag, ".ack_lo"},   32'(ack),         32'd0);
        valid = 1'b0;
        @(negedge clk);
        check({tag, ".strobe_off"}, 32'(data_strobe), 32'd0);
        check({tag, ".done"},       32'(burst_done),  32'(last));
        check({tag, ".ack_next"},   32'(ack),         32'(!last));
    endtask

    initial begin
        rst = 1'b1;
        request = 1'b0; valid = 1'b0; data_in = '0;
        request1 = 1'b0; valid1 = 1'b0; data_in1 = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset.dut1_ack",    32'(ack1),    32'd0);
        check("reset.dut1_notice", 32'(notice1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal 3-word burst: 5, 2, 7
        start_burst("norm");
        send_word("norm.w0", 3'd5, 2'd1, 1'b0);
        send_word("norm.w1", 3'd2, 2'd2, 1'b0);
        send_word("norm.w2", 3'd7, 2'd3, 1'b1);
        request = 1'b0;
        @(negedge clk);
        check("norm.done_pulse", 32'(burst_done), 32'd0);
        check("norm.idle_ack",   32'(ack),        32'd0);
        check("norm.idle_cnt",   32'(word_cnt),   32'd3);
        check("norm.idle_data",  32'(data),       32'd7);

        // Stall in WAIT_DATA: ack holds for 8 cycles, then error
        start_burst("stall");
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall.ack_hold", 32'(ack),   32'd1);
            check("stall.no_err",   32'(error), 32'd0);
        end
        @(negedge clk);
        check("stall.ack_drop", 32'(ack),   32'd0);
        check("stall.error",    32'(error), 32'd1);
        request = 1'b0;
        @(negedge clk);
        check("stall.err_sticky", 32'(error),  32'd1);
        check("stall.no_notice",  32'(notice), 32'd0);

        // Next request clears error; drop request before any word
        start_burst("clr");
        request = 1'b0;
        @(negedge clk);
        check("abort0.ack",  32'(ack),        32'd0);
        check("abort0.err",  32'(error),      32'd0);
        check("abort0.done", 32'(burst_done), 32'd0);

        // valid stuck high after word 1
        start_burst("stuck");
        valid = 1'b1; data_in = 3'd6;
        @(negedge clk);
        check("stuck.data", 32'(data),     32'd6);
        check("stuck.cnt",  32'(word_cnt), 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stuck.no_err", 32'(error), 32'd0);
        end
        @(negedge clk);
        check("stuck.error", 32'(error),    32'd1);
        check("stuck.cnt1",  32'(word_cnt), 32'd1);
        check("stuck.data1", 32'(data),     32'd6);
        check("stuck.ack",   32'(ack),      32'd0);
        valid = 1'b0; request = 1'b0;
        @(negedge clk);
        check("stuck.idle_ack",    32'(ack),    32'd0);
        check("stuck.idle_notice", 32'(notice), 32'd0);

        // Request dropped in WAIT_DATA after 2 words
        start_burst("drop");
        send_word("drop.w0", 3'd3, 2'd1, 1'b0);
        send_word("drop.w1", 3'd4, 2'd2, 1'b0);
        request = 1'b0;
        @(negedge clk);
        check("drop.ack",    32'(ack),        32'd0);
        check("drop.err",    32'(error),      32'd0);
        check("drop.done",   32'(burst_done), 32'd0);
        check("drop.cnt",    32'(word_cnt),   32'd2);
        check("drop.notice", 32'(notice),     32'd0);
        @(negedge clk);
        check("drop.still_idle", 32'(ack), 32'd0);

        // Reset during NOTICE
        request = 1'b1;
        @(negedge clk);
        check("rst1.notice_on", 32'(notice), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst1");
        rst = 1'b0; request = 1'b0;
        @(negedge clk);

        // Reset during WAIT_RELEASE
        start_burst("rst2");
        valid = 1'b1; data_in = 3'd5;
        @(negedge clk);
        check("rst2.cnt", 32'(word_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst2");
        rst = 1'b0; valid = 1'b0; request = 1'b0;
        @(negedge clk);

        // Normal burst after reset
        start_burst("post");
        send_word("post.w0", 3'd1, 2'd1, 1'b0);
        send_word("post.w1", 3'd2, 2'd2, 1'b0);
        send_word("post.w2", 3'd3, 2'd3, 1'b1);
        request = 1'b0;
        @(negedge clk);

        // Single-word bursts back to back, request held high
        request1 = 1'b1;
        @(negedge clk);
        check("b1.notice_a", 32'(notice1), 32'd1);
        @(negedge clk);
        check("b1.notice_b", 32'(notice1), 32'd1);
        check("b1.ack_lo",   32'(ack1),    32'd0);
        @(negedge clk);
        check("b1.notice_off", 32'(notice1), 32'd0);
        check("b1.ack_on",     32'(ack1),    32'd1);
        valid1 = 1'b1; data_in1 = 8'hA5;
        @(negedge clk);
        check("b1.data",   32'(data1),        32'hA5);
        check("b1.strobe", 32'(data_strobe1), 32'd1);
        check("b1.cnt",    32'(word_cnt1),    32'd1);
        valid1 = 1'b0;
        @(negedge clk);
        check("b1.done",   32'(burst_done1), 32'd1);
        check("b1.ack_lo2", 32'(ack1),       32'd0);
        @(negedge clk);
        check("b1.restart_notice", 32'(notice1),     32'd1);
        check("b1.done_pulse",     32'(burst_done1), 32'd0);
        check("b1.cnt_clr",        32'(word_cnt1),   32'd0);
        check("b1.data_held",      32'(data1),       32'hA5);
        request1 = 1'b0;
        repeat (4) @(negedge clk);
        check("b1.final_idle_ack", 32'(ack1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
